crank_wheel_gen: RTL and testbench
==================================

// Module: crank_wheel_gen
// PURPOSE
//  Synthetic crank trigger-wheel transmitter: emits a 0/1 tooth waveform for an N-M wheel (e.g. 60-2).
//  Each tooth lasts a programmable number of clocks, and a missing-tooth gap marks once per revolution.
//  Drives the hwag vr_in pin on the bench/board, so the capture, gap search and angle path runs without an engine.
//  Configuration comes from host registers on the same ssram bus; this block sees plain config inputs.
// PARAMETERS
//  PER_W   24  width of tooth period (clocks per tooth), matches HWAPCNT width
//  TTH_W   8   width of tooth count/index, matches HWATHVL width
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous reset, active-low
//  ena           in   1       run enable; low = idle, output held low
//  cfg_period    in   PER_W   clocks per tooth pitch; sampled only at tooth boundaries
//  cfg_teeth     in   TTH_W   total tooth positions per rev incl. missing (60)
//  cfg_missing   in   TTH_W   missing teeth at end of rev (2)
//  vr_out        out  1       generated tooth signal (registered)
//  tooth_idx     out  TTH_W   current tooth position 0..cfg_teeth-1
//  edge_stb      out  1       1-clk pulse coincident with each vr_out rising edge
//  rev_stb       out  1       1-clk pulse when tooth_idx wraps to 0
//  cfg_err       out  1       sticky: last start attempt had invalid config
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; vr_out=0, tooth_idx=0, pcnt=0, edge_stb=0, rev_stb=0, cfg_err=0.
//  States: IDLE, RUN.
//  IDLE: counters held 0, vr_out=0. On a clk edge with ena=1:
//   - cfg_teeth==0 or cfg_missing>=cfg_teeth -> cfg_err<=1, stay IDLE.
//   - else cfg_err<=0; latch shadows per_s=max(cfg_period,2), teeth_s, miss_s; go RUN.
//     On the same edge: pcnt<=0, tooth_idx<=0, vr_out<=1, edge_stb<=1, rev_stb<=1 (1-clk latency from ena).
//  RUN, per clock: pcnt counts 0..per_s-1.
//   - Tooth present iff tooth_idx < teeth_s-miss_s.
//   - vr_out=1 iff present and pcnt < per_s>>1, giving floor(P/2) high and P-floor(P/2) low.
//   - At pcnt==per_s-1: pcnt<=0; tooth_idx<=(tooth_idx==teeth_s-1)?0:tooth_idx+1.
//     per_s reloads from cfg_period (clamped >=2); teeth_s/miss_s reload only at rev wrap.
//     Reload with invalid teeth/missing -> keep old shadows, set cfg_err, keep running.
//   - edge_stb=1 on the cycle vr_out goes 0->1; rev_stb=1 on the first cycle of tooth_idx 0.
//  Revolution length = teeth_s*per_s clocks (constant period). Gap low time = (P-floor(P/2)) + miss_s*P.
//  ena falling in RUN: next edge -> IDLE, vr_out=0, counters 0, strobes 0. No tooth completion.
//  ena re-rise restarts at tooth 0.
//  cfg_period change mid-tooth: no effect until the next tooth boundary. The current tooth is never stretched or cut.
//  pcnt arithmetic is PER_W unsigned and never wraps, since its bound is per_s-1. tooth_idx never exceeds teeth_s-1.
//  Simultaneous ena=0 and boundary: ena wins (IDLE).
// STRUCTURE
//  Shared package hwag_gen_pkg:
//   - gen_state_t enum {IDLE,RUN}
//   - PER_W/TTH_W defaults
//   - GEN_MIN_PERIOD=2
//  One sub-module: crank_tooth_timer, holding the pcnt, per_s shadow, end-of-tooth strobe, and the high-phase compare.
//  Top holds the FSM, the tooth index, teeth/missing shadows, strobes and cfg_err.
// TESTING
//  1. P=10, 60-2, ena=1:
//     - vr_out 5 high/5 low for teeth 0..57, then 25 clks low.
//     - rev_stb every 600 clks; 58 edge_stb per rev.
//  2. Change cfg_period 10->20 mid tooth 3: tooth 3 stays 10 clks, tooth 4 is 20 clks (10 high/10 low).
//     cfg_period=1 -> tooth 2 clks (1/1).
//  3. cfg_teeth=4, cfg_missing=4 -> cfg_err=1, vr_out stays 0.
//     Then cfg_missing=1 -> cfg_err clears, pattern 3 teeth + 1 gap, rev=4*P.
//  4. ena dropped at pcnt=3 of tooth 7 -> next clk vr_out=0, tooth_idx=0.
//     ena re-raised -> vr_out=1, edge_stb and rev_stb on that edge.
//  5. Async rst low mid-tooth (between clk edges) -> outputs 0 immediately.
//     After release with ena=1: start on first clk edge.
//  6. Loopback into hwag (CAPE=1, MINCPR/MAXCPR bracketing P):
//     - hwag_start asserts after the first gap.
//     - gap-point flag once per 600-clk rev for 60-2, P=10.

Source files
------------

// File: rtl/hwag_gen_pkg.sv
// hwag_gen_pkg: shared types and constants for the synthetic crank-wheel generator.
// Revision 1.0
`default_nettype none

package hwag_gen_pkg;

  localparam int PER_W_DEF      = 24;
  localparam int TTH_W_DEF      = 8;
  localparam int GEN_MIN_PERIOD = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

endpackage

`default_nettype wire

// File: rtl/crank_tooth_timer.sv
// crank_tooth_timer: per-tooth clock counter, period shadow and high-phase compare.
// Revision 1.0
`default_nettype none

module crank_tooth_timer
  import hwag_gen_pkg::*;
#(
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  input  logic [PER_W-1:0] cfg_period,
  output logic             tooth_end,
  output logic             high_nxt
);

  logic [PER_W-1:0] pcnt;
  logic [PER_W-1:0] per_s;
  logic [PER_W-1:0] pcnt_nxt;
  logic [PER_W-1:0] per_nxt;
  logic [PER_W-1:0] per_cfg;

  // A period below two would leave no room for both a high and a low phase.
  assign per_cfg   = (cfg_period < PER_W'(GEN_MIN_PERIOD)) ? PER_W'(GEN_MIN_PERIOD) : cfg_period;
  assign tooth_end = (pcnt == (per_s - PER_W'(1)));

  always_comb begin
    pcnt_nxt = '0;
    per_nxt  = per_s;
    if (start) begin
      per_nxt = per_cfg;
    end else if (advance) begin
      if (tooth_end) begin
        per_nxt = per_cfg;
      end else begin
        pcnt_nxt = pcnt + PER_W'(1);
      end
    end
  end

  // Evaluated on next-cycle values so the top can register vr_out directly.
  assign high_nxt = (pcnt_nxt < (per_nxt >> 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      per_s <= PER_W'(GEN_MIN_PERIOD);
    end else begin
      pcnt  <= pcnt_nxt;
      per_s <= per_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: N-M crank trigger-wheel waveform generator with missing-tooth gap.
// Revision 1.0
`default_nettype none

module crank_wheel_gen
  import hwag_gen_pkg::*;
#(
  parameter int PER_W = PER_W_DEF,
  parameter int TTH_W = TTH_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [TTH_W-1:0] cfg_teeth,
  input  logic [TTH_W-1:0] cfg_missing,
  output logic             vr_out,
  output logic [TTH_W-1:0] tooth_idx,
  output logic             edge_stb,
  output logic             rev_stb,
  output logic             cfg_err
);

  gen_state_t       state, state_nxt;
  logic [TTH_W-1:0] teeth_s, miss_s;
  logic [TTH_W-1:0] teeth_nxt, miss_nxt, idx_nxt;
  logic             err_nxt;
  logic             t_start, t_adv;
  logic             run_nxt, rev_nxt;
  logic             tooth_end, high_nxt;
  logic             cfg_ok, present_nxt, vr_nxt, edge_nxt;

  crank_tooth_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (t_start),
    .advance    (t_adv),
    .cfg_period (cfg_period),
    .tooth_end  (tooth_end),
    .high_nxt   (high_nxt)
  );

  assign cfg_ok = (cfg_teeth != '0) && (cfg_missing < cfg_teeth);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = tooth_idx;
    teeth_nxt = teeth_s;
    miss_nxt  = miss_s;
    err_nxt   = cfg_err;
    t_start   = 1'b0;
    t_adv     = 1'b0;
    run_nxt   = 1'b0;
    rev_nxt   = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (ena) begin
          if (!cfg_ok) begin
            err_nxt = 1'b1;
          end else begin
            err_nxt   = 1'b0;
            teeth_nxt = cfg_teeth;
            miss_nxt  = cfg_missing;
            t_start   = 1'b1;
            run_nxt   = 1'b1;
            rev_nxt   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!ena) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          t_adv   = 1'b1;
          run_nxt = 1'b1;
          if (tooth_end) begin
            if (tooth_idx == (teeth_s - TTH_W'(1))) begin
              idx_nxt = '0;
              rev_nxt = 1'b1;
              // Wheel geometry only changes on a revolution boundary; a bad
              // request is flagged but the current wheel keeps spinning.
              if (cfg_ok) begin
                teeth_nxt = cfg_teeth;
                miss_nxt  = cfg_missing;
              end else begin
                err_nxt = 1'b1;
              end
            end else begin
              idx_nxt = tooth_idx + TTH_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign present_nxt = (idx_nxt < (teeth_nxt - miss_nxt));
  assign vr_nxt      = run_nxt & present_nxt & high_nxt;
  assign edge_nxt    = vr_nxt & ~vr_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vr_out    <= 1'b0;
      tooth_idx <= '0;
      edge_stb  <= 1'b0;
      rev_stb   <= 1'b0;
      cfg_err   <= 1'b0;
      teeth_s   <= '0;
      miss_s    <= '0;
    end else begin
      vr_out    <= vr_nxt;
      tooth_idx <= idx_nxt;
      edge_stb  <= edge_nxt;
      rev_stb   <= rev_nxt;
      cfg_err   <= err_nxt;
      teeth_s   <= teeth_nxt;
      miss_s    <= miss_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: table-driven, directed and randomized checks against a wheel reference model.
`default_nettype none

module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [23:0] cfg_period = 24'd10;
  logic [7:0]  cfg_teeth = 8'd60;
  logic [7:0]  cfg_missing = 8'd2;
  logic        vr_out;
  logic [7:0]  tooth_idx;
  logic        edge_stb;
  logic        rev_stb;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  crank_wheel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .cfg_period  (cfg_period),
    .cfg_teeth   (cfg_teeth),
    .cfg_missing (cfg_missing),
    .vr_out      (vr_out),
    .tooth_idx   (tooth_idx),
    .edge_stb    (edge_stb),
    .rev_stb     (rev_stb),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: position within the wheel as (tooth, clocks elapsed in tooth).
  bit m_run, m_err, m_vr, m_edge, m_rev;
  int m_idx, m_el, m_P, m_T, m_M;

  function automatic void model_reset();
    m_run = 0; m_err = 0; m_vr = 0; m_edge = 0; m_rev = 0;
    m_idx = 0; m_el = 0; m_P = 2; m_T = 0; m_M = 0;
  endfunction

  function automatic void model_step();
    int cp, ct, cm;
    bit ok, prev;
    cp = int'(cfg_period); ct = int'(cfg_teeth); cm = int'(cfg_missing);
    ok = (ct != 0) && (cm < ct);
    prev = m_vr;
    if (!rst) begin
      model_reset();
      return;
    end
    m_rev = 0;
    if (!m_run) begin
      if (ena) begin
        if (!ok) m_err = 1;
        else begin
          m_err = 0; m_P = (cp < 2) ? 2 : cp; m_T = ct; m_M = cm;
          m_run = 1; m_idx = 0; m_el = 0; m_rev = 1;
        end
      end
    end else if (!ena) begin
      m_run = 0; m_idx = 0; m_el = 0;
    end else begin
      m_el++;
      if (m_el == m_P) begin
        m_el = 0;
        m_P = (cp < 2) ? 2 : cp;
        if (m_idx == m_T - 1) begin
          m_idx = 0; m_rev = 1;
          if (ok) begin m_T = ct; m_M = cm; end
          else m_err = 1;
        end else m_idx++;
      end
    end
    m_vr = m_run && (m_idx < m_T - m_M) && (m_el < m_P / 2);
    m_edge = m_vr && !prev;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle{err,rev,edge,idx,vr}", {cfg_err, rev_stb, edge_stb, tooth_idx, vr_out},
        {m_err, m_rev, m_edge, m_idx[7:0], m_vr});
  endtask

  task automatic wait_idx(input int v);
    int g;
    g = 0;
    while (int'(tooth_idx) != v && g < 2000) begin
      tick();
      g++;
    end
    chk("wait_idx", 64'(tooth_idx), 64'(v));
  endtask

  task automatic restart(input int p, input int t, input int m);
    ena = 1'b0;
    tick();
    cfg_period = 24'(p); cfg_teeth = 8'(t); cfg_missing = 8'(m);
    ena = 1'b1;
  endtask

  typedef struct {
    int period;
    int teeth;
    int missing;
    int rev_len;
    int edges;
    int max_low;
    bit err;
  } row_t;

  row_t tbl[7];

  task automatic run_row(input row_t r, input int n);
    int win, nrev, p1, p2, edges, lowrun, maxlow;
    nrev = 0; p1 = 0; p2 = 0; edges = 0; lowrun = 0; maxlow = 0;
    restart(r.period, r.teeth, r.missing);
    win = (r.rev_len > 0) ? 3 * r.rev_len + 20 : 40;
    for (int c = 0; c < win; c++) begin
      tick();
      if (rev_stb) begin
        nrev++;
        if (nrev == 1) p1 = c;
        else if (nrev == 2) p2 = c;
      end
      if (nrev == 1 && edge_stb) edges++;
      if (!vr_out) begin
        lowrun++;
        if (nrev == 1 && lowrun > maxlow) maxlow = lowrun;
      end else lowrun = 0;
    end
    chk($sformatf("row%0d_rev_len", n), 64'((nrev >= 2) ? p2 - p1 : 0), 64'(r.rev_len));
    chk($sformatf("row%0d_edges", n), 64'(edges), 64'(r.edges));
    chk($sformatf("row%0d_gap_low", n), 64'(maxlow), 64'(r.max_low));
    chk($sformatf("row%0d_cfg_err", n), 64'(cfg_err), 64'(r.err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, hi;
    // period, teeth, missing, rev length, edges per rev, longest low run, cfg_err
    tbl[0] = '{10, 60, 2, 600, 58, 25, 1'b0};
    tbl[1] = '{1,  4,  1, 8,   3,  3,  1'b0};
    tbl[2] = '{7,  4,  4, 0,   0,  0,  1'b1};
    tbl[3] = '{7,  4,  1, 28,  3,  11, 1'b0};
    tbl[4] = '{9,  5,  0, 45,  5,  5,  1'b0};
    tbl[5] = '{5,  0,  0, 0,   0,  0,  1'b1};
    tbl[6] = '{4,  3,  2, 12,  1,  10, 1'b0};

    model_reset();
    #12;
    chk("reset_state", {cfg_err, rev_stb, edge_stb, tooth_idx, vr_out}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_row(tbl[i], i);

    // Period change mid-tooth takes effect only at the next tooth boundary.
    restart(10, 60, 2);
    wait_idx(3);
    len = 0;
    while (tooth_idx == 8'd3 && len < 100) begin
      len++;
      if (len == 3) cfg_period = 24'd20;
      tick();
    end
    chk("tooth3_len", 64'(len), 64'd10);
    len = 0; hi = 0;
    while (tooth_idx == 8'd4 && len < 100) begin
      len++;
      if (vr_out) hi++;
      if (len == 5) cfg_period = 24'd1;
      tick();
    end
    chk("tooth4_len", 64'(len), 64'd20);
    chk("tooth4_high", 64'(hi), 64'd10);
    len = 0; hi = 0;
    while (tooth_idx == 8'd5 && len < 100) begin
      len++;
      if (vr_out) hi++;
      tick();
    end
    chk("tooth5_len", 64'(len), 64'd2);
    chk("tooth5_high", 64'(hi), 64'd1);

    // Dropping ena mid-tooth returns straight to idle; re-raising restarts at tooth 0.
    restart(10, 60, 2);
    wait_idx(7);
    repeat (3) tick();
    ena = 1'b0;
    tick();
    chk("ena_drop_vr", 64'(vr_out), 64'd0);
    chk("ena_drop_idx", 64'(tooth_idx), 64'd0);
    ena = 1'b1;
    tick();
    chk("ena_rise_strobes", {vr_out, edge_stb, rev_stb, tooth_idx}, {3'b111, 8'd0});

    // Invalid geometry requested mid-run: flagged at the wrap, old wheel kept.
    restart(2, 4, 1);
    tick();
    cfg_teeth = 8'd3; cfg_missing = 8'd5;
    repeat (12) tick();
    chk("reload_invalid_err", 64'(cfg_err), 64'd1);
    chk("reload_invalid_run", 64'(m_T), 64'd4);

    // Asynchronous reset between clock edges.
    restart(10, 60, 2);
    wait_idx(2);
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {cfg_err, rev_stb, edge_stb, tooth_idx, vr_out}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("restart_after_reset", {vr_out, edge_stb, rev_stb}, 64'b111);

    // Randomized configuration and enable activity.
    cfg_teeth = 8'd6; cfg_missing = 8'd1; cfg_period = 24'd3;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) ena = ~ena;
      if ($urandom_range(0, 29) == 0) cfg_period = 24'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) begin
        cfg_teeth = 8'($urandom_range(0, 8));
        cfg_missing = 8'($urandom_range(0, 8));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
